rle_enc: RTL
============

Name: rle_enc

Overview:
- Run-length encoder that sits directly downstream of the sampler.
- Consumes the sampler's decimated output stream and collapses consecutive identical samples into one output record: {first sample, event, repeat count}.
- Feeds the capture memory writer, which reduces memory use for slowly changing inputs.
- Can be bypassed at runtime, so that every sample passes through with count 0.

Parameters:
SDW, 32, sample data width
SEW, 1, sample event width
RCW, 8, run counter width; count field holds repetitions minus one (0..2^RCW-1)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
cfg_ena  input  1  1: RLE enabled; 0: bypass (each sample emitted with count 0)
cfg_msk  input  SDW  compare mask; bit=1 means the bit takes part in the equality test
ctl_flush  input  1  level; while high, input is stalled and any pending run is closed
sts_empty  output  1  high when no pending run and no output record held
sti_tready  output  1  input stream ready
sti_tvalid  input  1  input stream valid
sti_tevent  input  SEW  input sample event flags
sti_tdata  input  SDW  input sample data
sto_tready  input  1  output stream ready
sto_tvalid  output  1  output stream valid
sto_tevent  output  SEW  event flags of the run's first sample
sto_tdata  output  SDW  data of the run's first sample
sto_tcount  output  RCW  run length minus one

Behaviour:
- State: run register {run_vld, run_data, run_evt, run_cnt} and output register {out_vld, out_data, out_evt, out_cnt}.
- sto_* reflect the output register; sto_tvalid = out_vld.
- Reset: all valid flags 0 and all data/event/count fields 0. sto_tvalid=0, sts_empty=1. A pending run is discarded (never emitted). Reset mid-transfer drops the held record.
- slot_free = !out_vld || sto_tready.
- sti_tready = slot_free && !ctl_flush. This is a combinational function of registered state and the sto_tready/ctl_flush inputs only; it never depends on sti_tdata.
- Input beat accepted when sti_tvalid && sti_tready. Output beat consumed when sto_tvalid && sto_tready. Consuming clears out_vld unless a new record loads in the same cycle.
- Merge condition, evaluated on an accepted beat, requires all of:
  - run_vld
  - (sti_tdata & cfg_msk) == (run_data & cfg_msk)
  - run_evt == 0 and sti_tevent == 0
  - run_cnt != 2^RCW-1
- Merge: run_cnt+1; data and event are unchanged (the first sample is kept).
- Close: accepted beat, run_vld, merge false:
  - the run moves into the output register;
  - the new sample loads the run register with cnt=0.
  - Any sample with an event bit set therefore always starts a fresh run and cannot absorb later samples.
- Start: accepted beat with !run_vld loads the run register with cnt=0.
- Saturation: when the count is at maximum, the next matching sample closes the run (count 2^RCW-1) and starts a new run at 0. The count never wraps.
- Flush: while ctl_flush=1 and run_vld and slot_free, the run moves to the output register and run_vld is cleared. If there is no run, flush does nothing. Inputs are never accepted while ctl_flush=1.
- Bypass (cfg_ena=0): an accepted beat loads the output register directly with cnt=0; the run register is not used. Latency is 1 cycle, with full throughput when sto_tready=1.
- Enabled latency: a record appears the cycle after its closing beat or flush.
- cfg_ena and cfg_msk may change only while sts_empty=1; behaviour otherwise is undefined.
- sts_empty = !run_vld && !out_vld (registered-state decode).
- Throughput: one input per cycle while sto_tready=1.
- Backpressure: the output register is held stable while sto_tvalid && !sto_tready.

Decomposition:
- Package ols_pkg holds:
  - the output record field order for memory packing: {tevent, tcount, tdata};
  - the RLE count encoding constant (count = length-1).
- Module parameters remain per-instance.
- One sub-module is natural: str_reg, a one-entry stream output register (valid/ready with load enable). The same sub-module is reused by other pipeline stages.
- Compare and run logic stay in rle_enc.

Test Plan:
1. Bypass: cfg_ena=0, sto_tready=1, data 0..7, event 0 -> eight records (d,evt0,cnt0), each 1 cycle after input, sti_tready constantly 1.
2. Basic runs: cfg_ena=1, data 5,5,5,9, then ctl_flush -> (5,cnt2) then (9,cnt0); sts_empty=1 afterwards.
3. Saturation: RCW=2, seven samples of 3, then flush -> (3,cnt3), (3,cnt2).
4. Events: data 4,4 with event=1,4,4, then flush -> (4,evt0,cnt0), (4,evt1,cnt0), (4,evt0,cnt1).
5. Mask: cfg_msk=0xFFFFFF00, data 0x12,0x34,0x56,0x100, then flush -> (0x12,cnt2), (0x100,cnt0).
6. Backpressure and reset:
   - sto_tready pattern 1,0,0,1 repeating, distinct data 0..15 -> all 16 records in order, no loss or duplication; sti_tready=0 whenever out_vld && !sto_tready.
   - Then rst asserted with a pending run -> no emission, sto_tvalid=0 and sts_empty=1 on the next cycle.

Source files
------------

// File: rtl/ols_pkg.sv
// Shared definitions for the sampler -> run-length encoder -> capture writer pipeline.
// Record layout and count encoding live here so every stage packs records identically.
package ols_pkg;

   // Record fields from MSB to LSB as packed into capture memory: {tevent, tcount, tdata}.
   typedef enum logic [1:0] {
      FLD_TEVENT = 2'd0,
      FLD_TCOUNT = 2'd1,
      FLD_TDATA  = 2'd2
   } rec_field_e;

   // A run of length L is stored with count L - RLE_CNT_BIAS.
   localparam int unsigned RLE_CNT_BIAS = 1;

   typedef enum logic [2:0] {
      ACT_IDLE,
      ACT_START,
      ACT_MERGE,
      ACT_CLOSE,
      ACT_FLUSH,
      ACT_BYPASS
   } rle_act_e;

   function automatic int unsigned rec_width(input int unsigned sdw,
                                             input int unsigned sew,
                                             input int unsigned rcw);
      return sdw + sew + rcw;
   endfunction

endpackage

// File: rtl/rle_enc_if.sv
// Sample input stream and run-record output stream of the run-length encoder.
// The slave modport is the encoder's view; master is the surrounding pipeline's view.
interface rle_enc_if #(
   parameter int SDW = 32,
   parameter int SEW = 1,
   parameter int RCW = 8
);

   logic           sti_tready;
   logic           sti_tvalid;
   logic [SEW-1:0] sti_tevent;
   logic [SDW-1:0] sti_tdata;

   logic           sto_tready;
   logic           sto_tvalid;
   logic [SEW-1:0] sto_tevent;
   logic [SDW-1:0] sto_tdata;
   logic [RCW-1:0] sto_tcount;

   modport slave (
      output sti_tready,
      input  sti_tvalid, sti_tevent, sti_tdata,
      input  sto_tready,
      output sto_tvalid, sto_tevent, sto_tdata, sto_tcount
   );

   modport master (
      input  sti_tready,
      output sti_tvalid, sti_tevent, sti_tdata,
      output sto_tready,
      input  sto_tvalid, sto_tevent, sto_tdata, sto_tcount
   );

endinterface

// File: rtl/rle_enc_str_reg.sv
// One-entry stream output register: holds a record until the consumer takes it.
// The owner may assert load only while free is high, which keeps a stalled record stable.
module str_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic         free
);

   assign free = !valid || ready;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments let every register sample pre-edge values; blocking here would create ordering races.
      if (rst) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rle_enc.sv
// Run-length encoder: collapses consecutive equal (masked) samples into one
// {first sample, event, repeat count} record; bypass passes every sample through with count 0.
module rle_enc
   import ols_pkg::*;
#(
   parameter int SDW = 32,
   parameter int SEW = 1,
   parameter int RCW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_ena,
   input  logic [SDW-1:0] cfg_msk,
   input  logic           ctl_flush,
   output logic           sts_empty,
   rle_enc_if.slave       bus
);

   localparam int unsigned    REC_W     = rec_width(SDW, SEW, RCW);
   localparam logic [RCW-1:0] CNT_FIRST = RCW'(1 - RLE_CNT_BIAS);
   localparam logic [RCW-1:0] CNT_MAX   = '1;

   logic           run_vld;
   logic [SDW-1:0] run_data;
   logic [SEW-1:0] run_evt;
   logic [RCW-1:0] run_cnt;

   logic             slot_free;
   logic             out_vld;
   logic             out_load;
   logic [REC_W-1:0] out_din;
   logic [REC_W-1:0] out_rec;

   logic     acc;
   logic     same_data;
   logic     merge_ok;
   rle_act_e act;

   assign bus.sti_tready = slot_free && !ctl_flush;
   assign acc            = bus.sti_tvalid && bus.sti_tready;

   // Events never merge: a flagged sample must stay addressable as its own record.
   assign same_data = ((bus.sti_tdata ^ run_data) & cfg_msk) == '0;
   assign merge_ok  = run_vld && same_data && (run_evt == '0) &&
                      (bus.sti_tevent == '0) && (run_cnt != CNT_MAX);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
      act      = ACT_IDLE;
      out_load = 1'b0;
      out_din  = {run_evt, run_cnt, run_data};

      if (!cfg_ena) begin
         if (acc) act = ACT_BYPASS;
      end else if (ctl_flush) begin
         if (run_vld && slot_free) act = ACT_FLUSH;
      end else if (acc) begin
         if (!run_vld)     act = ACT_START;
         else if (merge_ok) act = ACT_MERGE;
         else               act = ACT_CLOSE;
      end

      case (act)
         ACT_BYPASS: begin
            out_load = 1'b1;
            out_din  = {bus.sti_tevent, CNT_FIRST, bus.sti_tdata};
         end
         ACT_CLOSE, ACT_FLUSH: out_load = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: data fields are cleared on reset too, so a post-reset record never carries stale bits.
      if (rst) begin
         run_vld  <= 1'b0;
         run_data <= '0;
         run_evt  <= '0;
         run_cnt  <= '0;
      end else begin
         case (act)
            ACT_START, ACT_CLOSE: begin
               run_vld  <= 1'b1;
               run_data <= bus.sti_tdata;
               run_evt  <= bus.sti_tevent;
               run_cnt  <= CNT_FIRST;
            end
            ACT_MERGE: run_cnt <= run_cnt + 1'b1;
            ACT_FLUSH: run_vld <= 1'b0;
            default: ;
         endcase
      end
   end

   str_reg #(.W(REC_W)) u_out (
      .clk   (clk),
      .rst   (rst),
      .load  (out_load),
      .din   (out_din),
      .ready (bus.sto_tready),
      .valid (out_vld),
      .dout  (out_rec),
      .free  (slot_free)
   );

   assign bus.sto_tvalid = out_vld;
   assign {bus.sto_tevent, bus.sto_tcount, bus.sto_tdata} = out_rec;
   assign sts_empty = !run_vld && !out_vld;

endmodule
